// File: rtl/banked_mem_model_if.sv
// rtl/banked_mem_model_if.sv - request/response bundle between the cache controller and the banked memory model
interface banked_mem_model_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data_in;
    logic              wr;
    logic              rd;
    logic [15:0]       data_out;
    logic              rd_valid;
    logic              stall;
    logic [3:0]        busy;
    logic              err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, rd_valid, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, rd_valid, stall, busy, err
    );
endinterface

// File: rtl/banked_mem_model.sv
// rtl/banked_mem_model.sv - four-bank word-interleaved memory model, optional BANKMEM_ALIGN_CHECK_EN
module banked_mem_model #(
    parameter int ADDR_W      = 16,
    parameter int BANK_CYCLES = 4,
    parameter int RD_LAT      = 2
) (
    input  logic               clk,
    input  logic               rst,
    banked_mem_model_if.slave  bus
);
    localparam int CNT_W = $clog2(BANK_CYCLES);
    localparam int WORDS = 2 ** (ADDR_W - 1);

    logic [15:0]       r_mem [WORDS];
    logic [CNT_W-1:0]  r_cnt [4];
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [15:0]       r_pipe_data [RD_LAT];

    logic              w_req;
    logic [1:0]        w_bank;
    logic [ADDR_W-2:0] w_word;
    logic              w_align_err;
    logic              w_err;
    logic              w_bank_busy;
    logic              w_accept;
    logic [3:0]        w_busy;

    assign w_req  = bus.rd ^ bus.wr;
    assign w_bank = bus.addr[2:1];
    assign w_word = bus.addr[ADDR_W-1:1];

`ifdef BANKMEM_ALIGN_CHECK_EN
    // A byte-odd address is meaningless for a 16-bit word memory; reject it.
    assign w_align_err = (bus.rd | bus.wr) & bus.addr[0];
`else
    // Byte offset is ignored: an odd address hits the containing word.
    assign w_align_err = 1'b0 & bus.addr[0];
`endif

    assign w_err       = (bus.rd & bus.wr) | w_align_err;
    assign w_bank_busy = w_busy[w_bank];
    assign w_accept    = w_req & ~w_bank_busy & ~w_err;

    // A bank is occupied while its down-counter is non-zero.
    always_comb begin
        w_busy = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            w_busy[b] = (r_cnt[b] != '0);
        end
    end

    assign bus.busy     = w_busy;
    assign bus.stall    = w_req & w_bank_busy;
    assign bus.err      = w_err;
    assign bus.rd_valid = r_pipe_vld[RD_LAT-1];
    assign bus.data_out = r_pipe_vld[RD_LAT-1] ? r_pipe_data[RD_LAT-1] : 16'h0000;

    // Per-bank occupancy counters: load on accept, otherwise count down to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_accept && (w_bank == 2'(b))) begin
                    r_cnt[b] <= CNT_W'(BANK_CYCLES - 1);
                end else if (r_cnt[b] != '0) begin
                    r_cnt[b] <= r_cnt[b] - 1'b1;
                end
            end
        end
    end

    // Array writes; contents deliberately survive rst so accepted writes persist.
    always_ff @(posedge clk) begin
        if (!rst && w_accept && bus.wr) begin
            r_mem[w_word] <= bus.data_in;
        end
    end

    // Fixed-latency read pipeline; the array is sampled before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_pipe_data[k] <= 16'h0000;
            end
        end else begin
            r_pipe_vld[0]  <= w_accept & bus.rd;
            r_pipe_data[0] <= (w_accept & bus.rd) ? r_mem[w_word] : 16'h0000;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pipe_vld[k]  <= r_pipe_vld[k-1];
                r_pipe_data[k] <= r_pipe_data[k-1];
            end
        end
    end
endmodule
